// File: rtl/imm_pkg.sv
// Shared types for the immediate-select path: select codes, opcodes and decode result.
package imm_pkg;

  typedef enum logic [5:0] {
    IMM_I     = 6'b000000,
    IMM_S     = 6'b001001,
    IMM_B     = 6'b010010,
    IMM_U     = 6'b011011,
    IMM_J     = 6'b100100,
    IMM_SHAMT = 6'b101101,
    IMM_ZIMM  = 6'b110110
  } imm_sel_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    imm_sel_t sel;
    logic     uses_imm;
    logic     illegal;
  } imm_dec_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode/funct3 -> immediate-select classifier.
// IMM_SEL_ZICSR_EN enables the CSR immediate (zimm) forms of SYSTEM.
module imm_sel_decode
  import imm_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output imm_dec_t   dec_o
);

  always_comb begin
    dec_o.sel      = IMM_I;
    dec_o.uses_imm = 1'b1;
    dec_o.illegal  = 1'b0;
    case (opcode_i)
      OPC_OP_IMM, OPC_OP_IMM32: begin
        if (funct3_i == 3'b001 || funct3_i == 3'b101) dec_o.sel = IMM_SHAMT;
      end
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM: ;
      OPC_STORE:            dec_o.sel = IMM_S;
      OPC_BRANCH:           dec_o.sel = IMM_B;
      OPC_LUI, OPC_AUIPC:   dec_o.sel = IMM_U;
      OPC_JAL:              dec_o.sel = IMM_J;
      OPC_OP, OPC_OP32:     dec_o.uses_imm = 1'b0;
      OPC_SYSTEM: begin
        if (funct3_i == 3'b100) begin
          dec_o.uses_imm = 1'b0;
          dec_o.illegal  = 1'b1;
        end else if (funct3_i[2]) begin
`ifdef IMM_SEL_ZICSR_EN
          dec_o.sel = IMM_ZIMM;
`else
          dec_o.uses_imm = 1'b0;
          dec_o.illegal  = 1'b1;
`endif
        end
      end
      default: begin
        dec_o.uses_imm = 1'b0;
        dec_o.illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_sel_stage.sv
// Immediate-select decode stage with a 2-entry skid buffer toward execute.
// Decode behaviour depends on IMM_SEL_ZICSR_EN (see imm_sel_decode).
module imm_sel_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [5:0]      out_imm_sel,
  output logic            out_uses_imm,
  output logic            out_illegal
);

  localparam imm_dec_t DecReset = '{sel: IMM_I, uses_imm: 1'b0, illegal: 1'b0};

  imm_dec_t in_dec;

  imm_sel_decode u_decode (
    .opcode_i (in_instr[6:0]),
    .funct3_i (in_instr[14:12]),
    .dec_o    (in_dec)
  );

  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [ILEN-1:0] main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  imm_dec_t        main_dec_q, main_dec_d, skid_dec_q, skid_dec_d;
  logic            accept;

  // in_ready comes straight from a flop so it never depends on out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    main_dec_d   = main_dec_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_dec_d   = skid_dec_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      // Skid has priority; accept cannot coincide because in_ready is low then.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
        main_instr_d = skid_instr_q;
        main_pc_d    = skid_pc_q;
        main_dec_d   = skid_dec_q;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
        main_pc_d    = in_pc;
        main_dec_d   = in_dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = in_instr;
      skid_pc_d    = in_pc;
      skid_dec_d   = in_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_instr_q <= '0;
      main_pc_q    <= '0;
      main_dec_q   <= DecReset;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      skid_dec_q   <= DecReset;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      main_dec_q   <= main_dec_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_dec_q   <= skid_dec_d;
    end
  end

  assign out_valid    = main_valid_q;
  assign out_instr    = main_instr_q;
  assign out_pc       = main_pc_q;
  assign out_imm_sel  = main_dec_q.sel;
  assign out_uses_imm = main_dec_q.uses_imm;
  assign out_illegal  = main_dec_q.illegal;

endmodule

// File: tb/tb_imm_sel_stage.sv
// Scoreboard bench for imm_sel_stage: expected entries queued on accept, checked on delivery.
module tb_imm_sel_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, out_instr;
  logic [63:0] in_pc, out_pc;
  logic [5:0]  out_imm_sel;
  logic        out_uses_imm, out_illegal;

  imm_sel_stage #(.XLEN(64), .ILEN(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm_sel  (out_imm_sel),
    .out_uses_imm (out_uses_imm),
    .out_illegal  (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [5:0]  sel;
    logic        uses;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  exp_t got;
  int   checks = 0;
  int   failures = 0;

  assign got = {out_instr, out_pc, out_imm_sel, out_uses_imm, out_illegal};

  // Reference decode table, written from the opcode list independently of the RTL.
  function automatic exp_t mk(input logic [31:0] ins, input logic [63:0] pc);
    exp_t r;
    logic [2:0] f3;
    f3 = ins[14:12];
    r.instr = ins; r.pc = pc; r.sel = 6'b000000; r.uses = 1'b1; r.ill = 1'b0;
    case (ins[6:0])
      7'b0010011, 7'b0011011: if (f3 == 3'b001 || f3 == 3'b101) r.sel = 6'b101101;
      7'b0000011, 7'b1100111, 7'b0001111: r.sel = 6'b000000;
      7'b0100011: r.sel = 6'b001001;
      7'b1100011: r.sel = 6'b010010;
      7'b0110111, 7'b0010111: r.sel = 6'b011011;
      7'b1101111: r.sel = 6'b100100;
      7'b0110011, 7'b0111011: r.uses = 1'b0;
      7'b1110011: begin
        if (f3 == 3'b100) begin
          r.uses = 1'b0; r.ill = 1'b1;
        end else if (f3[2]) begin
`ifdef IMM_SEL_ZICSR_EN
          r.sel = 6'b110110;
`else
          r.uses = 1'b0; r.ill = 1'b1;
`endif
        end
      end
      default: begin r.uses = 1'b0; r.ill = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h1000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (got !== '0) begin failures++;
      $display("FAIL reset_data: got %h want 0", got); end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_no_capture: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] ins [4] = '{32'h00500093, 32'h00209093, 32'h00112023, 32'hFE000EE3};
    logic [5:0]  sels [4] = '{6'b000000, 6'b101101, 6'b001001, 6'b010010};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_pc = 64'h8000_0000 + 64'(4 * i);
      exp_q.push_back({ins[i], 64'h8000_0000 + 64'(4 * i), sels[i], 1'b1, 1'b0});
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin failures++;
        $display("FAIL stream_valid[%0d]: got v=%b r=%b want 1 1", i, out_valid, in_ready); end
      e = exp_q.pop_front();
      checks++; if (got !== e) begin failures++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, got, e); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL stream_end: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [9] = '{32'h0000007F, 32'h305F5073, 32'h00000073, 32'h00004073,
                             32'h000000B7, 32'h0000006F, 32'h00000033, 32'h0000501B,
                             32'h0000001B};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_instr = ins[i]; in_pc = 64'h2000 + 64'(4 * i);
      exp_q.push_back(mk(ins[i], 64'h2000 + 64'(4 * i)));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || got !== e) begin failures++;
        $display("FAIL decode[%0d]: got v=%b %h want %h", i, out_valid, got, e); end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00A00113; in_pc = 64'h3000; exp_q.push_back(mk(in_instr, in_pc));
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instr !== 32'h00A00113) begin
      failures++; $display("FAIL bp_a_main: got v=%b r=%b %h want 1 1 00a00113",
                           out_valid, in_ready, out_instr); end
    in_instr = 32'h00112223; in_pc = 64'h3004; exp_q.push_back(mk(in_instr, in_pc));
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00A00113) begin failures++;
      $display("FAIL bp_b_skid: got r=%b %h want 0 00a00113", in_ready, out_instr); end
    in_instr = 32'h000011B7; in_pc = 64'h3008;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h00A00113) begin
      failures++; $display("FAIL bp_c_refused: got r=%b v=%b %h want 0 1 00a00113",
                           in_ready, out_valid, out_instr); end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++; if (got !== e) begin failures++;
      $display("FAIL bp_deliver_a: got %h want %h", got, e); end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || got !== e) begin failures++;
      $display("FAIL bp_deliver_b: got v=%b %h want %h", out_valid, got, e); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    exp_q.push_back(mk(in_instr, in_pc));
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || got !== e) begin failures++;
      $display("FAIL bp_deliver_c: got v=%b %h want %h", out_valid, got, e); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++;
      $display("FAIL bp_end: got v=%b q=%0d want 0 0", out_valid, exp_q.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00100093; in_pc = 64'h4000;
    @(negedge clk);
    in_instr = 32'h00200093; in_pc = 64'h4004;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++;
      $display("FAIL flush_setup: got r=%b want 0", in_ready); end
    flush = 1'b1; in_instr = 32'h00300093; in_pc = 64'h4008;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h00100093) begin
      failures++; $display("FAIL flush_full: got v=%b r=%b %h want 0 1 00100093",
                           out_valid, in_ready, out_instr); end
    in_valid = 1'b1; in_instr = 32'h00400093; in_pc = 64'h400C;
    @(negedge clk);
    flush = 1'b1; in_instr = 32'h00500093; in_pc = 64'h4010;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'h00400093) begin failures++;
      $display("FAIL flush_drop_accept: got v=%b %h want 0 00400093", out_valid, out_instr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL flush_after: got v=%b r=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [5] = '{32'h123450B7, 32'h00000117, 32'h0080006F, 32'h0000A183,
                             32'h002081B3};
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00C50513; in_pc = 64'h5000; exp_q.push_back(mk(in_instr, in_pc));
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || got !== e) begin failures++;
        $display("FAIL b2b[%0d]: got r=%b v=%b %h want 1 1 %h", i, in_ready, out_valid, got, e);
      end
      if (i < 5) begin
        in_instr = ins[i]; in_pc = 64'h5004 + 64'(4 * i);
        exp_q.push_back(mk(in_instr, in_pc));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++;
      $display("FAIL b2b_end: got v=%b q=%0d want 0 0", out_valid, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00600093; in_pc = 64'h6000;
    @(negedge clk);
    in_instr = 32'h00700093; in_pc = 64'h6004;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin failures++;
      $display("FAIL reset_mid: got v=%b r=%b %h want 0 1 0", out_valid, in_ready, got); end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_mid_after: got %b want 0", out_valid); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_stream();
    test_illegal();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
